// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM encodings,
// parity codes, divisor floor and the data-bit-count decode.
package uart_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [15:0] MIN_DIVISOR = 16'd2;

    // Index of the last data bit (count - 1): code 00 -> 4 (5 bits) ... 11 -> 7 (8 bits).
    function automatic logic [2:0] last_data_bit(input logic [1:0] code);
        return 3'd4 + {1'b0, code};
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte-stream handshake between the UART register block (master) and the transmitter (slave).
interface uart_tx_cfg_if;

    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;

    modport master (
        output tx_data,
        output tx_data_valid,
        input  tx_data_ready
    );

    modport slave (
        input  tx_data,
        input  tx_data_valid,
        output tx_data_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for TX bytes; the head entry is readable
// combinationally so a pop and the frame load happen on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign full  = (level_reg == DEPTH_L);
    assign empty = (level_reg == '0);
    assign level = level_reg;

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, N/E/O parity, 1/2 stop, runtime divisor).
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int UART_CLK_HZ = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DEF_DIVISOR = UART_CLK_HZ / BAUD_RATE,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_div_override,
    input  logic [15:0]                   cfg_divisor,
    input  logic [1:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    uart_tx_cfg_if.slave                  tx_if,
    output logic                          tx_pin,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic       ready_en_reg;
    logic       push;
    logic       pop;
    logic       q_full;
    logic       q_empty;
    logic [7:0] q_data;

    tx_state_t   state_reg, state_next;
    logic [15:0] cyc_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
    logic        parity_reg;
    logic [15:0] div_reg;
    logic [2:0]  last_bit_reg;
    logic [1:0]  par_mode_reg;
    logic        stop2_reg;
    logic        stop_cnt_reg;
    logic        tx_pin_reg;
    logic        pin_next;
    logic        bit_done;
    logic        par_on;
    logic [15:0] div_sel;
    logic [15:0] div_eff;

    // Ready stays low during reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    assign tx_if.tx_data_ready = ready_en_reg & ~q_full;
    assign push                = tx_if.tx_data_valid & tx_if.tx_data_ready;

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (tx_if.tx_data),
        .pop   (pop),
        .rdata (q_data),
        .full  (q_full),
        .empty (q_empty),
        .level (fifo_level)
    );
`else
    logic       hold_valid_reg;
    logic [7:0] hold_data_reg;

    // Push needs an empty holder and pop a full one, so they never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else if (push) begin
            hold_valid_reg <= 1'b1;
            hold_data_reg  <= tx_if.tx_data;
        end else if (pop) begin
            hold_valid_reg <= 1'b0;
        end
    end

    assign q_full     = hold_valid_reg;
    assign q_empty    = ~hold_valid_reg;
    assign q_data     = hold_data_reg;
    assign fifo_level = {{(LW-1){1'b0}}, hold_valid_reg};
`endif

    assign div_sel  = cfg_div_override ? cfg_divisor : DEF_DIVISOR[15:0];
    assign div_eff  = (div_sel < MIN_DIVISOR) ? MIN_DIVISOR : div_sel;
    assign bit_done = (cyc_cnt_reg == div_reg - 16'd1);
    assign par_on   = (par_mode_reg == PAR_EVEN) || (par_mode_reg == PAR_ODD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        pin_next   = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                pin_next = 1'b0;
                if (bit_done) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                pin_next = shift_reg[0];
                if (bit_done && (bit_cnt_reg == last_bit_reg)) begin
                    state_next = par_on ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                pin_next = parity_reg ^ (par_mode_reg == PAR_ODD);
                if (bit_done) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Chain straight into the next frame when a byte is waiting.
                if (bit_done && (stop_cnt_reg || !stop2_reg)) begin
                    if (!q_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Configuration is captured with the byte, so a frame never sees mid-frame cfg edits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            div_reg      <= MIN_DIVISOR;
            last_bit_reg <= 3'd7;
            par_mode_reg <= PAR_NONE;
            stop2_reg    <= 1'b0;
            stop_cnt_reg <= 1'b0;
            tx_pin_reg   <= 1'b1;
        end else begin
            tx_pin_reg <= pin_next;
            if (pop) begin
                cyc_cnt_reg  <= '0;
                bit_cnt_reg  <= '0;
                shift_reg    <= q_data;
                parity_reg   <= 1'b0;
                div_reg      <= div_eff;
                last_bit_reg <= last_data_bit(cfg_data_bits);
                par_mode_reg <= cfg_parity;
                stop2_reg    <= cfg_stop2;
                stop_cnt_reg <= 1'b0;
            end else if (state_reg != ST_IDLE) begin
                if (bit_done) begin
                    cyc_cnt_reg <= '0;
                    if (state_reg == ST_DATA) begin
                        parity_reg  <= parity_reg ^ shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    end
                    if (state_reg == ST_STOP) begin
                        stop_cnt_reg <= 1'b1;
                    end
                end else begin
                    cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign tx_pin  = tx_pin_reg;
    assign tx_busy = (state_reg != ST_IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame bit patterns, timing, queueing and reset abort.
module tb_uart_tx_cfg;

    localparam int FIFO_DEPTH = 16;
`ifdef UART_TX_FIFO_EN
    localparam int QDEPTH = FIFO_DEPTH;
`else
    localparam int QDEPTH = 1;
`endif
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_div_override;
    logic [15:0]   cfg_divisor;
    logic [1:0]    cfg_data_bits;
    logic [1:0]    cfg_parity;
    logic          cfg_stop2;
    logic          tx_pin;
    logic          tx_busy;
    logic [LW-1:0] fifo_level;

    uart_tx_cfg_if tx_if();

    uart_tx_cfg #(
        .UART_CLK_HZ (50000000),
        .BAUD_RATE   (115200),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_div_override (cfg_div_override),
        .cfg_divisor      (cfg_divisor),
        .cfg_data_bits    (cfg_data_bits),
        .cfg_parity       (cfg_parity),
        .cfg_stop2        (cfg_stop2),
        .tx_if            (tx_if),
        .tx_pin           (tx_pin),
        .tx_busy          (tx_busy),
        .fifo_level       (fifo_level)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic ovr, input logic [15:0] div, input logic [1:0] bits,
                           input logic [1:0] par, input logic stop2);
        @(negedge clk);
        cfg_div_override = ovr;
        cfg_divisor      = div;
        cfg_data_bits    = bits;
        cfg_parity       = par;
        cfg_stop2        = stop2;
    endtask

    // Returns just after the accepting edge; valid is dropped 1 ns later unless keep is set.
    task automatic send_byte(input logic [7:0] d, input bit keep);
        int w;
        @(negedge clk);
        tx_if.tx_data       = d;
        tx_if.tx_data_valid = 1'b1;
        w = 0;
        while (!tx_if.tx_data_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (!tx_if.tx_data_ready) check("send_ready_timeout", tx_if.tx_data_ready, 1);
        @(posedge clk);
        if (!keep) #1 tx_if.tx_data_valid = 1'b0;
    endtask

    // Counts falling edges until tx_pin is seen low (bounded).
    task automatic wait_start(input string tag, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_pin && n < max);
        check(tag, tx_pin, 0);
    endtask

    // Entered at the first falling edge of a frame; samples the first and last clock of each bit.
    task automatic check_bits(input string tag, input logic [15:0] bits, input int n, input int div);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < div; c++) begin
                if (c == 0 || c == div - 1)
                    check($sformatf("%s_bit%0d_c%0d", tag, k, c), tx_pin, bits[k]);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nq;
        int lows;
        logic [7:0] d;

        cfg_div_override    = 1'b0;
        cfg_divisor         = 16'd0;
        cfg_data_bits       = 2'b11;
        cfg_parity          = 2'b00;
        cfg_stop2           = 1'b0;
        tx_if.tx_data       = 8'h00;
        tx_if.tx_data_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pin", tx_pin, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", tx_if.tx_data_ready, 0);
        rst = 1'b0;
        #1 check("rel_ready_pre", tx_if.tx_data_ready, 0);
        @(negedge clk);
        check("rel_ready_post", tx_if.tx_data_ready, 1);

        // 1: default 8N1, divisor 434, 0x55
        send_byte(8'h55, 0);
        wait_start("t1_start", 10, n);
        check("t1_latency", n - 1, 2);
        check("t1_busy", tx_busy, 1);
        check_bits("t1", 16'b10_1010_1010, 10, 434);
        check("t1_busy_end", tx_busy, 0);
        check("t1_idle_pin", tx_pin, 1);

        // 2: divisor 4, 7E2, 0x41 -> 44-clock frame
        set_cfg(1'b1, 16'd4, 2'b10, 2'b01, 1'b1);
        send_byte(8'h41, 0);
        wait_start("t2_start", 10, n);
        check_bits("t2", 16'b110_1000_0010, 11, 4);
        check("t2_busy_end", tx_busy, 0);
        check("t2_idle_pin", tx_pin, 1);

        // 3: divisor 4, 5O1, 0xFF: upper bits dropped, parity 0
        set_cfg(1'b1, 16'd4, 2'b00, 2'b10, 1'b0);
        send_byte(8'hFF, 0);
        wait_start("t3_start", 10, n);
        check_bits("t3", 16'b1011_1110, 8, 4);
        check("t3_busy_end", tx_busy, 0);

        // 3b: divisor 3, 6 bits, reserved parity code behaves as none, 0x2A
        set_cfg(1'b1, 16'd3, 2'b01, 2'b11, 1'b0);
        send_byte(8'h2A, 0);
        wait_start("t3b_start", 10, n);
        check_bits("t3b", 16'b1101_0100, 8, 3);
        check("t3b_busy_end", tx_busy, 0);

        // 5: divisor 1 and 0 both clamp to 2 clocks per bit
        set_cfg(1'b1, 16'd1, 2'b00, 2'b00, 1'b0);
        send_byte(8'h00, 0);
        wait_start("t5a_start", 10, n);
        check_bits("t5a", 16'b100_0000, 7, 2);
        check("t5a_busy_end", tx_busy, 0);
        set_cfg(1'b1, 16'd0, 2'b00, 2'b00, 1'b0);
        send_byte(8'h15, 0);
        wait_start("t5b_start", 10, n);
        check_bits("t5b", 16'b110_1010, 7, 2);
        check("t5b_busy_end", tx_busy, 0);

        // 5c: parity changed mid-frame only affects the following frame
        set_cfg(1'b1, 16'd3, 2'b11, 2'b01, 1'b0);
        fork
            begin
                send_byte(8'h03, 0);
                send_byte(8'h03, 0);
                @(negedge clk);
                cfg_parity = 2'b10;
            end
            begin
                wait_start("t5c_start", 50, n);
                check_bits("t5c_even", 16'b100_0000_0110, 11, 3);
                check_bits("t5c_odd", 16'b110_0000_0110, 11, 3);
            end
        join
        check("t5c_busy_end", tx_busy, 0);

        // 4: burst of 17 bytes, divisor 2, 8N1, frames back-to-back
        set_cfg(1'b1, 16'd2, 2'b11, 2'b00, 1'b0);
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    d = 8'hA0 + 8'(i);
                    send_byte(d, i != 16);
                end
                @(negedge clk);
                check("t4_level_full", fifo_level, QDEPTH);
                check("t4_ready_full", tx_if.tx_data_ready, 0);
            end
            begin
                logic [7:0] e;
                wait_start("t4_start", 100, n);
                for (int i = 0; i < 17; i++) begin
                    e = 8'hA0 + 8'(i);
                    check_bits($sformatf("t4_f%0d", i), {6'b0, 1'b1, e, 1'b0}, 10, 2);
                end
                check("t4_busy_end", tx_busy, 0);
                check("t4_idle_pin", tx_pin, 1);
            end
        join

        // 6: reset mid-DATA with bytes queued aborts everything
        set_cfg(1'b1, 16'd4, 2'b11, 2'b00, 1'b0);
        nq = (QDEPTH >= 3) ? 3 : QDEPTH;
        fork
            begin
                for (int i = 0; i <= nq; i++) send_byte(8'h00, i != nq);
            end
            wait_start("t6_start", 50, n);
        join
        repeat (12) @(negedge clk);
        check("t6_pre_pin", tx_pin, 0);
        check("t6_pre_level", fifo_level, nq);
        rst = 1'b1;
        #1;
        check("t6_rst_pin", tx_pin, 1);
        check("t6_rst_busy", tx_busy, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_ready", tx_if.tx_data_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("t6_rel_ready_pre", tx_if.tx_data_ready, 0);
        @(negedge clk);
        check("t6_rel_ready_post", tx_if.tx_data_ready, 1);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (!tx_pin) lows++;
        end
        check("t6_no_stale", lows, 0);
        check("t6_busy", tx_busy, 0);
        check("t6_level", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
